// File: rtl/pipeline_stall_unit_if.sv
// Decode/execute/memory hazard inputs and pipeline control outputs of the stall unit.
interface pipeline_stall_unit_if #(
    parameter int CNT_W = 16,
    parameter int REG_W = 4
);
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic             mem_write_id;
    logic             cond_branch_id;
    logic             branch_taken_id;
    logic             hlt_id;
    logic             mem_read_ex;
    logic             flag_write_ex;
    logic [REG_W-1:0] dst_reg_ex;
    logic             mem_req_m;
    logic             mem_ready_m;
    logic             pc_stall;
    logic             fd_stall;
    logic             fd_flush;
    logic             dx_flush;
    logic             freeze;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output rs_id, rt_id, use_rs_id, use_rt_id, mem_write_id, cond_branch_id,
               branch_taken_id, hlt_id, mem_read_ex, flag_write_ex, dst_reg_ex,
               mem_req_m, mem_ready_m,
        input  pc_stall, fd_stall, fd_flush, dx_flush, freeze, halted,
               stall_cycles, flush_count
    );

    modport slave (
        input  rs_id, rt_id, use_rs_id, use_rt_id, mem_write_id, cond_branch_id,
               branch_taken_id, hlt_id, mem_read_ex, flag_write_ex, dst_reg_ex,
               mem_req_m, mem_ready_m,
        output pc_stall, fd_stall, fd_flush, dx_flush, freeze, halted,
               stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_unit.sv
// Resolves hazards forwarding cannot cover: load-use, flag-dependent branches,
// taken-branch redirect, data-memory waits and HLT; counts stall and flush cycles.
module pipeline_stall_unit #(
    parameter int CNT_W = 16,
    parameter int REG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_stall_unit_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BUBBLE   = 2'd2,
        HALT     = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_hz_s, fl_hz_s, mem_wait_s;
    logic             pc_stall_s, fd_stall_s, fd_flush_s, dx_flush_s, freeze_s, halted_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        logic [CNT_W-1:0] r;
        if (en && (v != {CNT_W{1'b1}})) begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Store data (rt of a store) is excluded: the loaded value reaches it by M->M forwarding.
    assign lu_hz_s = bus.mem_read_ex && (bus.dst_reg_ex != {REG_W{1'b0}}) &&
                     ((bus.use_rs_id && (bus.dst_reg_ex == bus.rs_id)) ||
                      (bus.use_rt_id && (bus.dst_reg_ex == bus.rt_id) && !bus.mem_write_id));
    assign fl_hz_s    = bus.cond_branch_id && bus.flag_write_ex;
    assign mem_wait_s = bus.mem_req_m && !bus.mem_ready_m;

    // Next state and pipeline controls; MEM_WAIT and BUBBLE re-evaluate the RUN rules each cycle.
    always_comb begin
        state_d    = state_q;
        pc_stall_s = 1'b0;
        fd_stall_s = 1'b0;
        fd_flush_s = 1'b0;
        dx_flush_s = 1'b0;
        freeze_s   = 1'b0;
        halted_s   = 1'b0;
        case (state_q)
            RUN, MEM_WAIT, BUBBLE: begin
                if (mem_wait_s) begin
                    freeze_s   = 1'b1;
                    pc_stall_s = 1'b1;
                    fd_stall_s = 1'b1;
                    state_d    = MEM_WAIT;
                end else if (lu_hz_s || fl_hz_s) begin
                    pc_stall_s = 1'b1;
                    fd_stall_s = 1'b1;
                    dx_flush_s = 1'b1;
                    state_d    = BUBBLE;
                end else if (bus.hlt_id) begin
                    pc_stall_s = 1'b1;
                    fd_flush_s = 1'b1;
                    state_d    = HALT;
                end else if (bus.branch_taken_id) begin
                    fd_flush_s = 1'b1;
                    state_d    = RUN;
                end else begin
                    state_d    = RUN;
                end
            end
            HALT: begin
                pc_stall_s = 1'b1;
                fd_flush_s = 1'b1;
                halted_s   = 1'b1;
                freeze_s   = mem_wait_s;
                state_d    = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall_cnt_d = sat_inc(stall_cnt_q, pc_stall_s);
    assign flush_cnt_d = sat_inc(flush_cnt_q, fd_flush_s);

    // State and saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.pc_stall     = pc_stall_s;
    assign bus.fd_stall     = fd_stall_s;
    assign bus.fd_flush     = fd_flush_s;
    assign bus.dx_flush     = dx_flush_s;
    assign bus.freeze       = freeze_s;
    assign bus.halted       = halted_s;
    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_stall_unit.sv
// Self-checking bench: vector table, directed multi-cycle sequences, random run vs. a rule model.
module tb_pipeline_stall_unit;
    localparam int CNT_W = 16;
    localparam int REG_W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipeline_stall_unit_if #(.CNT_W(CNT_W), .REG_W(REG_W)) bus ();
    pipeline_stall_unit #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // expected control word: {pc_stall, fd_stall, fd_flush, dx_flush, freeze, halted}
    typedef struct {
        logic [3:0] rs, rt, dst;
        logic use_rs, use_rt, mw, cb, bt, hlt, mr, fw, req, rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mkv(input logic [3:0] rs, rt, dst,
                                 input logic use_rs, use_rt, mw, cb, bt, hlt, mr, fw, req, rdy,
                                 input logic [5:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.dst = dst; v.use_rs = use_rs; v.use_rt = use_rt; v.mw = mw;
        v.cb = cb; v.bt = bt; v.hlt = hlt; v.mr = mr; v.fw = fw; v.req = req; v.rdy = rdy;
        v.exp = exp;
        return v;
    endfunction

    function automatic logic [5:0] ctrl();
        return {bus.pc_stall, bus.fd_stall, bus.fd_flush, bus.dx_flush, bus.freeze, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.rs_id = v.rs; bus.rt_id = v.rt; bus.dst_reg_ex = v.dst;
        bus.use_rs_id = v.use_rs; bus.use_rt_id = v.use_rt; bus.mem_write_id = v.mw;
        bus.cond_branch_id = v.cb; bus.branch_taken_id = v.bt; bus.hlt_id = v.hlt;
        bus.mem_read_ex = v.mr; bus.flag_write_ex = v.fw;
        bus.mem_req_m = v.req; bus.mem_ready_m = v.rdy;
    endtask

    task automatic idle();
        drive(mkv(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
    endtask

    // Rule-level reference: what the pipeline should be told given whether it is halted.
    function automatic logic [5:0] ref_ctrl(input bit halted);
        bit mw, lu, fl;
        mw = bus.mem_req_m && !bus.mem_ready_m;
        lu = bus.mem_read_ex && bus.dst_reg_ex != 4'd0 &&
             ((bus.use_rs_id && bus.dst_reg_ex == bus.rs_id) ||
              (bus.use_rt_id && bus.dst_reg_ex == bus.rt_id && !bus.mem_write_id));
        fl = bus.cond_branch_id && bus.flag_write_ex;
        if (halted)                return {5'b10100, 1'b0} | {4'b0000, mw, 1'b1};
        if (mw)                    return 6'b110010;
        if (lu || fl)              return 6'b110100;
        if (bus.hlt_id)            return 6'b101000;
        if (bus.branch_taken_id)   return 6'b001000;
        return 6'b000000;
    endfunction

    initial begin
        vec_t v;
        bit   m_halted;
        int   m_stall, m_flush;
        logic [5:0] e;

        //           rs    rt    dst  urs  urt  mw   cb   bt   hlt  mr   fw   req  rdy  exp
        tbl[0]  = mkv(4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 6'b000000);
        tbl[1]  = mkv(4'd3, 4'd1, 4'd3, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 6'b110100);
        tbl[2]  = mkv(4'd1, 4'd3, 4'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000);
        tbl[3]  = mkv(4'd1, 4'd3, 4'd3, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 6'b110100);
        tbl[4]  = mkv(4'd0, 4'd0, 4'd0, 1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000);
        tbl[5]  = mkv(4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0, 6'b110100);
        tbl[6]  = mkv(4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 6'b001000);
        tbl[7]  = mkv(4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 6'b101000);
        tbl[8]  = mkv(4'd3, 4'd0, 4'd3, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 6'b110010);
        tbl[9]  = mkv(4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 6'b000000);
        tbl[10] = mkv(4'd3, 4'd0, 4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000);
        tbl[11] = mkv(4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 6'b101000);
        tbl[12] = mkv(4'd3, 4'd0, 4'd5, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 6'b000000);

        idle();
        #3;
        chk("reset_ctrl", {26'd0, ctrl()}, 32'd0);
        chk("reset_stall_cnt", {16'd0, bus.stall_cycles}, 32'd0);
        chk("reset_flush_cnt", {16'd0, bus.flush_count}, 32'd0);
        rst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < 13; i++) begin
            do_reset();
            drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("table_vec%0d", i), {26'd0, ctrl()}, {26'd0, tbl[i].exp});
        end

        // load-use bubble lasts exactly one cycle
        do_reset();
        drive(tbl[1]);
        @(negedge clk);
        chk("lu_bubble", {26'd0, ctrl()}, {26'd0, 6'b110100});
        next_cycle();
        idle();
        @(negedge clk);
        chk("lu_after", {26'd0, ctrl()}, 32'd0);
        chk("lu_stall_cnt", {16'd0, bus.stall_cycles}, 32'd1);

        // flag hazard holds off the taken redirect until flags are ready
        do_reset();
        drive(tbl[5]);
        @(negedge clk);
        chk("fl_bubble", {26'd0, ctrl()}, {26'd0, 6'b110100});
        next_cycle();
        bus.flag_write_ex = 1'b0;
        @(negedge clk);
        chk("fl_redirect", {26'd0, ctrl()}, {26'd0, 6'b001000});
        next_cycle();
        idle();
        @(negedge clk);
        chk("fl_flush_cnt", {16'd0, bus.flush_count}, 32'd1);
        chk("fl_stall_cnt", {16'd0, bus.stall_cycles}, 32'd1);

        // three-cycle memory wait with a pending load-use, bubble on the ready cycle
        do_reset();
        drive(tbl[8]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("mw_freeze%0d", i), {26'd0, ctrl()}, {26'd0, 6'b110010});
            next_cycle();
        end
        bus.mem_ready_m = 1'b1;
        @(negedge clk);
        chk("mw_ready_bubble", {26'd0, ctrl()}, {26'd0, 6'b110100});
        next_cycle();
        idle();
        @(negedge clk);
        chk("mw_stall_cnt", {16'd0, bus.stall_cycles}, 32'd4);

        // HLT held for 10 cycles, then asynchronous reset mid-halt
        do_reset();
        drive(tbl[7]);
        next_cycle();
        idle();
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("halt_ctrl%0d", i), {26'd0, ctrl()}, {26'd0, 6'b101001});
            next_cycle();
        end
        @(negedge clk);
        chk("halt_stall_cnt", {16'd0, bus.stall_cycles}, 32'd10);
        chk("halt_flush_cnt", {16'd0, bus.flush_count}, 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("halt_async_ctrl", {26'd0, ctrl()}, 32'd0);
        chk("halt_async_cnt", {16'd0, bus.stall_cycles}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        drive(tbl[6]);
        @(negedge clk);
        chk("halt_exit_run", {26'd0, ctrl()}, {26'd0, 6'b001000});

        // random traffic against the rule model
        do_reset();
        m_halted = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
        for (int n = 0; n < 3000; n++) begin
            v = mkv(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 399) == 0), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 6'd0);
            drive(v);
            @(negedge clk);
            e = ref_ctrl(m_halted);
            chk("rand_ctrl", {26'd0, ctrl()}, {26'd0, e});
            chk("rand_stall_cnt", {16'd0, bus.stall_cycles}, 32'(m_stall));
            chk("rand_flush_cnt", {16'd0, bus.flush_count}, 32'(m_flush));
            if (e[5] && m_stall < 65535) m_stall++;
            if (e[3] && m_flush < 65535) m_flush++;
            if (!m_halted && e == 6'b101000) m_halted = 1'b1;
            next_cycle();
        end

        // saturation: HALT for 2^CNT_W + 5 cycles
        do_reset();
        drive(tbl[7]);
        next_cycle();
        idle();
        for (int i = 1; i < (1 << CNT_W) + 5; i++) next_cycle();
        @(negedge clk);
        chk("sat_stall_cnt", {16'd0, bus.stall_cycles}, 32'hFFFF);
        chk("sat_flush_cnt", {16'd0, bus.flush_count}, 32'hFFFF);
        next_cycle();
        @(negedge clk);
        chk("sat_stall_hold", {16'd0, bus.stall_cycles}, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
